// File: rtl/uart_fifo_irq.sv
// ============================================================================
//  uart_fifo_irq
//  16550-style RX/TX FIFOs with per-entry error tracking, trigger levels,
//  character timeout and prioritised IIR/LSR interrupt logic.
//  Rev 1.0
// ============================================================================
`default_nettype none

module uart_fifo_irq #(
  parameter int DEPTH      = 16,
  parameter int TOUT_TICKS = 640
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_en,
  input  logic [1:0]             rx_trig,
  input  logic                   rx_clr,
  input  logic                   tx_clr,
  input  logic [3:0]             ier,
  input  logic                   tick16,
  input  logic                   rx_push,
  input  logic [7:0]             rx_din,
  input  logic                   rx_perr,
  input  logic                   rx_ferr,
  input  logic                   rx_brk,
  input  logic                   rbr_rd,
  input  logic                   lsr_rd,
  input  logic                   iir_rd,
  output logic [7:0]             rbr_dout,
  input  logic                   tx_wr,
  input  logic [7:0]             tx_din,
  input  logic                   tx_pop,
  input  logic                   tx_busy,
  output logic [7:0]             tx_dout,
  output logic                   tx_empty,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [7:0]             lsr,
  output logic [7:0]             iir,
  output logic                   irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TOUT_TICKS + 1);

  // Registered copy of FCR[0]: the active mode, and its mismatch flags a change.
  logic          r_fen;
  logic          w_fen_chg;
  logic [CW-1:0] w_cap;
  logic          w_unused;

  assign w_fen_chg = (fifo_en != r_fen);
  assign w_cap     = r_fen ? CW'(DEPTH) : CW'(1);
  assign w_unused  = ier[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fen <= 1'b0;
    else     r_fen <= fifo_en;
  end

  // ---------------- RX FIFO ----------------
  logic [10:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_rx_cnt, r_err_cnt;
  logic          r_mask, r_oe;
  logic          w_rx_empty, w_rx_full, w_rx_clr, w_rx_pop, w_rx_push, w_rx_ovr;
  logic [10:0]   w_rx_head, w_rx_in;
  logic [2:0]    w_head_flags;

  assign w_rx_empty   = (r_rx_cnt == '0);
  assign w_rx_full    = (r_rx_cnt >= w_cap);
  assign w_rx_clr     = rx_clr | w_fen_chg;
  assign w_rx_pop     = rbr_rd & !w_rx_empty;
  assign w_rx_push    = rx_push & (!w_rx_full | w_rx_pop);
  assign w_rx_ovr     = rx_push & w_rx_full & !w_rx_pop;
  assign w_rx_in      = {rx_brk, rx_ferr, rx_perr, rx_din};
  assign w_rx_head    = w_rx_empty ? 11'd0 : r_rx_mem[r_rx_rp];
  assign w_head_flags = r_mask ? 3'b000 : w_rx_head[10:8];

  always_ff @(posedge clk) begin
    if (w_rx_push && !w_rx_clr) r_rx_mem[r_rx_wp] <= w_rx_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (w_rx_clr) begin
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      r_rx_cnt  <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
      r_err_cnt <= r_err_cnt + CW'(w_rx_push & (|w_rx_in[10:8]))
                             - CW'(w_rx_pop & (|w_rx_head[10:8]));
    end
  end

  // Head flags hidden after an LSR read; a new head (pop, or push into empty) unmasks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_mask <= 1'b0;
    else if (w_rx_clr)                        r_mask <= 1'b0;
    else if (w_rx_pop || (w_rx_push && w_rx_empty)) r_mask <= 1'b0;
    else if (lsr_rd)                          r_mask <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_oe <= 1'b0;
    else if (w_fen_chg) r_oe <= 1'b0;
    else if (w_rx_ovr)  r_oe <= 1'b1;
    else if (lsr_rd)    r_oe <= 1'b0;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic          w_tx_empty, w_tx_full, w_tx_clr, w_tx_pop, w_tx_push;

  assign w_tx_empty   = (r_tx_cnt == '0);
  assign w_tx_full    = (r_tx_cnt >= w_cap);
  assign w_tx_clr     = tx_clr | w_fen_chg;
  assign w_tx_pop     = tx_pop & !w_tx_empty;
  assign w_tx_push    = tx_wr & (!w_tx_full | w_tx_pop);
  assign w_tx_cnt_nxt = w_tx_clr ? '0 : (r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop));

  always_ff @(posedge clk) begin
    if (w_tx_push && !w_tx_clr) r_tx_mem[r_tx_wp] <= tx_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      r_tx_cnt <= w_tx_cnt_nxt;
      if (w_tx_clr) begin
        r_tx_wp <= '0;
        r_tx_rp <= '0;
      end else begin
        if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
        if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      end
    end
  end

  // ---------------- Trigger level ----------------
  logic [CW-1:0] w_trig;

  always_comb begin
    w_trig = CW'(1);
    if (r_fen) begin
      case (rx_trig)
        2'b00:   w_trig = CW'(1);
        2'b01:   w_trig = CW'(DEPTH / 4);
        2'b10:   w_trig = CW'(DEPTH / 2);
        default: w_trig = CW'(DEPTH - 2);
      endcase
    end
  end

  // ---------------- Character timeout ----------------
  logic [TW-1:0] r_tout;
  logic          w_cti_pend;

  assign w_cti_pend = (r_tout == TW'(TOUT_TICKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tout <= '0;
    else if (rx_push || w_rx_pop || w_rx_clr || w_rx_empty)
      r_tout <= '0;
    else if (tick16 && r_fen && !w_cti_pend)
      r_tout <= r_tout + 1'b1;
  end

  // ---------------- THRE pending / IIR ----------------
  logic       r_ier1, r_thre_pend, r_irq;
  logic       w_thre_set, w_thre_clr;
  logic [3:0] w_iid;

  assign w_thre_set = (w_tx_cnt_nxt == '0) && ((r_tx_cnt != '0) || (ier[1] && !r_ier1));
  assign w_thre_clr = tx_wr || (iir_rd && (w_iid == 4'b0010));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ier1      <= 1'b0;
      r_thre_pend <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_ier1 <= ier[1];
      r_irq  <= !w_iid[0];
      if (w_thre_set)      r_thre_pend <= 1'b1;
      else if (w_thre_clr) r_thre_pend <= 1'b0;
    end
  end

  always_comb begin
    w_iid = 4'b0001;
    if (ier[2] && (r_oe || (|w_head_flags))) w_iid = 4'b0110;
    else if (ier[0] && (r_rx_cnt >= w_trig)) w_iid = 4'b0100;
    else if (ier[0] && w_cti_pend)           w_iid = 4'b1100;
    else if (ier[1] && r_thre_pend)          w_iid = 4'b0010;
  end

  // ---------------- Outputs ----------------
  assign rbr_dout = w_rx_head[7:0];
  assign tx_dout  = w_tx_empty ? 8'd0 : r_tx_mem[r_tx_rp];
  assign tx_empty = w_tx_empty;
  assign rx_count = r_rx_cnt;
  assign tx_count = r_tx_cnt;
  assign lsr      = {r_fen && (r_err_cnt != '0), w_tx_empty && !tx_busy, w_tx_empty,
                     w_head_flags[2], w_head_flags[1], w_head_flags[0], r_oe, !w_rx_empty};
  assign iir      = {r_fen, r_fen, 2'b00, w_iid};
  assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_irq.sv
// ============================================================================
//  tb_uart_fifo_irq
//  Table-driven plus directed-sequence self-checking bench for uart_fifo_irq.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_fifo_irq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_en = 1'b1;
  logic [1:0] rx_trig = 2'b10;
  logic       rx_clr = 0, tx_clr = 0;
  logic [3:0] ier = 4'h1;
  logic       tick16 = 0, rx_push = 0;
  logic [7:0] rx_din = 0;
  logic       rx_perr = 0, rx_ferr = 0, rx_brk = 0;
  logic       rbr_rd = 0, lsr_rd = 0, iir_rd = 0;
  logic [7:0] rbr_dout;
  logic       tx_wr = 0;
  logic [7:0] tx_din = 0;
  logic       tx_pop = 0, tx_busy = 0;
  logic [7:0] tx_dout;
  logic       tx_empty;
  logic [4:0] rx_count, tx_count;
  logic [7:0] lsr, iir;
  logic       irq;

  int checks = 0;
  int failures = 0;

  uart_fifo_irq #(.DEPTH(16), .TOUT_TICKS(640)) dut (
    .clk(clk), .rst(rst), .fifo_en(fifo_en), .rx_trig(rx_trig),
    .rx_clr(rx_clr), .tx_clr(tx_clr), .ier(ier), .tick16(tick16),
    .rx_push(rx_push), .rx_din(rx_din), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_brk(rx_brk), .rbr_rd(rbr_rd), .lsr_rd(lsr_rd), .iir_rd(iir_rd),
    .rbr_dout(rbr_dout), .tx_wr(tx_wr), .tx_din(tx_din), .tx_pop(tx_pop),
    .tx_busy(tx_busy), .tx_dout(tx_dout), .tx_empty(tx_empty),
    .rx_count(rx_count), .tx_count(tx_count), .lsr(lsr), .iir(iir), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [7:0] din;
    logic [2:0] err;   // {brk, ferr, perr}
    logic       pop;
    logic       lrd;
    logic       clr;
    logic [3:0] ie;
    logic [4:0] cnt;
    logic [7:0] lsr;
    logic [7:0] iir;
    logic [7:0] rbr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic push, input logic [7:0] din, input logic [2:0] err,
                     input logic pop, input logic lrd, input logic clr, input logic [3:0] ie,
                     input logic [4:0] cnt, input logic [7:0] el, input logic [7:0] ei,
                     input logic [7:0] er);
    vec_t v;
    v.push = push; v.din = din; v.err = err; v.pop = pop; v.lrd = lrd; v.clr = clr;
    v.ie = ie; v.cnt = cnt; v.lsr = el; v.iir = ei; v.rbr = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
    rx_push = 0; rbr_rd = 0; lsr_rd = 0; iir_rd = 0; rx_clr = 0; tx_clr = 0;
    tx_wr = 0; tx_pop = 0; tick16 = 0;
    {rx_brk, rx_ferr, rx_perr} = 3'b000;
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) begin
      tick16 = 1;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic prev_src;

    // Trigger / overrun / error-tracking table (DEPTH 16, trigger level 8).
    for (int i = 1; i <= 7; i++)
      add(1, 8'(i), 3'b000, 0, 0, 0, 4'h1, 5'(i), 8'h61, 8'hC1, 8'h01);
    add(1, 8'h08, 3'b000, 0, 0, 0, 4'h1, 5'd8,  8'h61, 8'hC4, 8'h01);
    add(0, 8'h00, 3'b000, 1, 0, 0, 4'h1, 5'd7,  8'h61, 8'hC1, 8'h02);
    for (int k = 1; k <= 9; k++)
      add(1, 8'(8 + k), 3'b000, 0, 0, 0, 4'h5, 5'(7 + k), 8'h61, 8'hC4, 8'h02);
    add(1, 8'hAA, 3'b000, 0, 0, 0, 4'h5, 5'd16, 8'h63, 8'hC6, 8'h02);
    add(0, 8'h00, 3'b000, 0, 1, 0, 4'h5, 5'd16, 8'h61, 8'hC4, 8'h02);
    add(1, 8'hBB, 3'b000, 1, 0, 0, 4'h5, 5'd16, 8'h61, 8'hC4, 8'h03);
    add(0, 8'h00, 3'b000, 0, 0, 1, 4'h5, 5'd0,  8'h60, 8'hC1, 8'h00);
    add(1, 8'h55, 3'b010, 0, 0, 0, 4'h5, 5'd1,  8'hE9, 8'hC6, 8'h55);
    add(1, 8'h66, 3'b000, 0, 0, 0, 4'h5, 5'd2,  8'hE9, 8'hC6, 8'h55);
    add(0, 8'h00, 3'b000, 0, 1, 0, 4'h5, 5'd2,  8'hE1, 8'hC1, 8'h55);
    add(0, 8'h00, 3'b000, 1, 0, 0, 4'h5, 5'd1,  8'h61, 8'hC1, 8'h66);
    add(1, 8'h77, 3'b101, 0, 0, 0, 4'h5, 5'd2,  8'hE1, 8'hC1, 8'h66);
    add(0, 8'h00, 3'b000, 1, 0, 0, 4'h5, 5'd1,  8'hF5, 8'hC6, 8'h77);
    add(0, 8'h00, 3'b000, 1, 0, 0, 4'h5, 5'd0,  8'h60, 8'hC1, 8'h00);
    add(0, 8'h00, 3'b000, 1, 0, 0, 4'h5, 5'd0,  8'h60, 8'hC1, 8'h00);

    // Reset values
    #2;
    chk("rst_lsr", lsr, 8'h60);
    chk("rst_iir", iir, 8'h01);
    chk("rst_irq", irq, 1'b0);
    chk("rst_tx_empty", tx_empty, 1'b1);
    @(posedge clk); #1; rst = 0;
    step();   // mode register picks up fifo_en=1
    chk("init_iir", iir, 8'hC1);

    prev_src = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      rx_push = vecs[i].push; rx_din = vecs[i].din;
      {rx_brk, rx_ferr, rx_perr} = vecs[i].err;
      rbr_rd = vecs[i].pop; lsr_rd = vecs[i].lrd; rx_clr = vecs[i].clr; ier = vecs[i].ie;
      step();
      chk($sformatf("v%0d_cnt", i), rx_count, vecs[i].cnt);
      chk($sformatf("v%0d_lsr", i), lsr, vecs[i].lsr);
      chk($sformatf("v%0d_iir", i), iir, vecs[i].iir);
      chk($sformatf("v%0d_rbr", i), rbr_dout, vecs[i].rbr);
      chk($sformatf("v%0d_irq", i), irq, prev_src);
      prev_src = (vecs[i].iir[0] == 1'b0);
    end

    // Character timeout
    ier = 4'h1;
    rx_push = 1; rx_din = 8'h11; step();
    rx_push = 1; rx_din = 8'h22; step();
    ticks(639);
    chk("cto_639", iir, 8'hC1);
    ticks(1);
    chk("cto_640", iir, 8'hCC);
    step();
    chk("cto_irq", irq, 1'b1);
    ticks(5);
    chk("cto_sat", iir, 8'hCC);
    rbr_rd = 1; step();
    chk("cto_pop_iir", iir, 8'hC1);
    chk("cto_pop_rbr", rbr_dout, 8'h22);
    ticks(639);
    chk("cto_restart_639", iir, 8'hC1);
    ticks(1);
    chk("cto_restart_640", iir, 8'hCC);
    rx_clr = 1; step();
    chk("cto_clr_cnt", rx_count, 5'd0);

    // THRE and 16450 mode
    ier = 4'h0; fifo_en = 0; step();
    ier = 4'h2; step();
    chk("thre_rise_iir", iir, 8'h02);
    tx_wr = 1; tx_din = 8'h31; step();
    chk("thre_wr_iir", iir, 8'h01);
    chk("thre_wr_cnt", tx_count, 5'd1);
    chk("thre_wr_dout", tx_dout, 8'h31);
    chk("thre_wr_empty", tx_empty, 1'b0);
    tx_wr = 1; tx_din = 8'h32; step();
    chk("tx_full_cnt", tx_count, 5'd1);
    chk("tx_full_dout", tx_dout, 8'h31);
    rx_push = 1; rx_din = 8'h41; step();
    rx_push = 1; rx_din = 8'h42; step();
    chk("m0_rx_cnt", rx_count, 5'd1);
    chk("m0_lsr", lsr, 8'h03);
    chk("m0_rbr", rbr_dout, 8'h41);
    tx_pop = 1; step();
    chk("thre_pop_iir", iir, 8'h02);
    chk("thre_pop_lsr", lsr, 8'h63);
    iir_rd = 1; step();
    chk("thre_iirrd", iir, 8'h01);
    fifo_en = 1; tx_wr = 1; tx_din = 8'h50; step();
    chk("fen_rx_cnt", rx_count, 5'd0);
    chk("fen_tx_cnt", tx_count, 5'd0);
    chk("fen_lsr", lsr, 8'h60);

    // Asynchronous reset mid-traffic
    ier = 4'h1;
    for (int i = 0; i < 8; i++) begin
      rx_push = 1; rx_din = 8'(8'hA0 + i); tx_wr = 1; tx_din = 8'(i); step();
    end
    step();
    chk("pre_rst_irq", irq, 1'b1);
    #3 rst = 1;
    #1;
    chk("arst_lsr", lsr, 8'h60);
    chk("arst_iir", iir, 8'h01);
    chk("arst_irq", irq, 1'b0);
    chk("arst_rx_cnt", rx_count, 5'd0);
    chk("arst_tx_cnt", tx_count, 5'd0);
    chk("arst_rbr", rbr_dout, 8'h00);
    chk("arst_txd", tx_dout, 8'h00);
    @(posedge clk); #1; rst = 0;
    step();
    chk("post_rst_iir", iir, 8'hC1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
